migration_switch_ctrl: RTL and testbench

- Packet-safe controller for the downstream interface selector; owns the `sel` bus that drives it.
- Sits directly upstream of the selector on the ingress stream, and taps the selector's egress stream.
- On a switch request it blocks new ingress packets at a packet boundary, waits for egress traffic to drain, updates `sel`, then reopens ingress.
- Guarantees that no packet is ever split across two interfaces during live migration.

---
 rtl/migration_switch_ctrl.sv | 142 ++++++++++++++
 tb/tb_migration_switch_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/migration_switch_ctrl.sv
// Packet-safe selector controller: closes ingress at a packet boundary, waits for the
// egress stream to go quiet, then moves `sel` to the requested interface.
module migration_switch_ctrl #(
    parameter int unsigned AXIS_DATA_WIDTH = 32,
    parameter int unsigned SEL_WIDTH       = 2,
    parameter int unsigned INTF_NUM        = 4,
    parameter int unsigned INIT_SEL        = 0,
    parameter int unsigned DRAIN_CYCLES    = 16
) (
    input  logic                         axis_aclk,
    input  logic                         axis_resetn,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [SEL_WIDTH-1:0]         req_sel,
    output logic                         done,
    output logic                         err,
    output logic                         busy,
    output logic [SEL_WIDTH-1:0]         sel,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    input  logic                         e_axis_tvalid,
    input  logic                         e_axis_tready,
    input  logic                         e_axis_tlast
);

    localparam int unsigned CntW = $clog2(DRAIN_CYCLES + 1);

    localparam logic [1:0] StRun    = 2'd0;
    localparam logic [1:0] StHold   = 2'd1;
    localparam logic [1:0] StDrain  = 2'd2;
    localparam logic [1:0] StSwitch = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [SEL_WIDTH-1:0] tgt_q, tgt_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 ing_pkt_q, ing_pkt_d;
    logic                 egr_pkt_q, egr_pkt_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 gate;
    logic                 ing_acc;
    logic                 egr_acc;

    // A packet already in flight may always finish; new packets only start in RUN.
    assign gate          = (state_q == StRun) || ing_pkt_q;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tvalid = s_axis_tvalid && gate;
    assign s_axis_tready = m_axis_tready && gate;

    assign ing_acc = m_axis_tvalid && m_axis_tready;
    assign egr_acc = e_axis_tvalid && e_axis_tready;

    assign req_ready = (state_q == StRun);
    assign busy      = (state_q != StRun);
    assign sel       = sel_q;
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ing_pkt_d = ing_pkt_q;
        egr_pkt_d = egr_pkt_q;

        if (ing_acc) ing_pkt_d = !s_axis_tlast;
        if (egr_acc) egr_pkt_d = !e_axis_tlast;

        case (state_q)
            StRun: begin
                if (req_valid) begin
                    if (32'(req_sel) >= INTF_NUM) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        tgt_d   = req_sel;
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (!ing_pkt_q) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Counter stops at DRAIN_CYCLES because the FSM leaves DRAIN there.
                if (cnt_q == CntW'(DRAIN_CYCLES)) begin
                    state_d = StSwitch;
                end else if (!egr_pkt_q && !e_axis_tvalid) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                end
            end
            StSwitch: begin
                sel_d   = tgt_q;
                done_d  = 1'b1;
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            state_q   <= StRun;
            sel_q     <= SEL_WIDTH'(INIT_SEL);
            tgt_q     <= SEL_WIDTH'(INIT_SEL);
            cnt_q     <= '0;
            ing_pkt_q <= 1'b0;
            egr_pkt_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            ing_pkt_q <= ing_pkt_d;
            egr_pkt_q <= egr_pkt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_migration_switch_ctrl.sv
// Directed bench for migration_switch_ctrl with DRAIN_CYCLES=4 and a 3-bit select so that
// out-of-range requests can be exercised.
module tb_migration_switch_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 3;

    logic          clk = 1'b0;
    logic          resetn;
    logic          req_valid, req_ready;
    logic [SW-1:0] req_sel;
    logic          done, err, busy;
    logic [SW-1:0] sel;
    logic [DW-1:0] s_tdata, m_tdata;
    logic [DW/8-1:0] s_tkeep, m_tkeep;
    logic          s_tvalid, s_tready, s_tlast;
    logic          m_tvalid, m_tready, m_tlast;
    logic          e_tvalid, e_tready, e_tlast;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    migration_switch_ctrl #(
        .AXIS_DATA_WIDTH(DW),
        .SEL_WIDTH      (SW),
        .INTF_NUM       (4),
        .INIT_SEL       (0),
        .DRAIN_CYCLES   (4)
    ) dut (
        .axis_aclk    (clk),
        .axis_resetn  (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_sel      (req_sel),
        .done         (done),
        .err          (err),
        .busy         (busy),
        .sel          (sel),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .e_axis_tvalid(e_tvalid),
        .e_axis_tready(e_tready),
        .e_axis_tlast (e_tlast)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one cycle; inputs are changed 1 time unit after the rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_sel = '0;
        s_tdata = '0; s_tkeep = '1; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        e_tvalid = 1'b0; e_tready = 1'b1; e_tlast = 1'b0;
        nxt(); nxt();
        #1;
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        resetn = 1'b1;
        nxt();

        // 1: idle switch to 2; busy cycles 1..7, result at cycle 8
        req_valid = 1'b1; req_sel = 3'd2;
        #1 chk("t1_req_ready_c0", 64'(req_ready), 64'd1);
        nxt();
        req_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            #1;
            chk($sformatf("t1_busy_c%0d", c), 64'(busy), 64'd1);
            chk($sformatf("t1_sel_c%0d", c), 64'(sel), 64'd0);
            chk($sformatf("t1_done_c%0d", c), 64'(done), 64'd0);
            nxt();
        end
        #1;
        chk("t1_sel_c8", 64'(sel), 64'd2);
        chk("t1_done_c8", 64'(done), 64'd1);
        chk("t1_err_c8", 64'(err), 64'd0);
        chk("t1_req_ready_c8", 64'(req_ready), 64'd1);
        nxt();
        #1 chk("t1_done_c9", 64'(done), 64'd0);

        // 6: backpressure in RUN
        s_tvalid = 1'b1; s_tdata = 32'hA5A5_0001; s_tlast = 1'b0; m_tready = 1'b0;
        #1;
        chk("t6_s_tready", 64'(s_tready), 64'd0);
        chk("t6_m_tvalid", 64'(m_tvalid), 64'd1);
        chk("t6_m_tdata", 64'(m_tdata), 64'hA5A5_0001);
        nxt(); nxt();
        #1;
        chk("t6_m_tdata_held", 64'(m_tdata), 64'hA5A5_0001);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_sel", 64'(sel), 64'd2);
        m_tready = 1'b1; s_tlast = 1'b1;
        #1 chk("t6_s_tready_rel", 64'(s_tready), 64'd1);
        nxt();
        s_tvalid = 1'b0; s_tlast = 1'b0;

        // 4: out-of-range request
        req_valid = 1'b1; req_sel = 3'd5;
        nxt();
        req_valid = 1'b0;
        #1;
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_err", 64'(err), 64'd1);
        chk("t4_sel", 64'(sel), 64'd2);
        chk("t4_busy", 64'(busy), 64'd0);
        nxt();
        #1;
        chk("t4_done_clr", 64'(done), 64'd0);
        chk("t4_busy2", 64'(busy), 64'd0);

        // 2: request arrives with beat 2 of a 5-beat packet
        s_tvalid = 1'b1; s_tdata = 32'h1; s_tlast = 1'b0;
        nxt();
        s_tdata = 32'h2; req_valid = 1'b1; req_sel = 3'd1;
        nxt();
        req_valid = 1'b0;
        for (int b = 3; b <= 5; b++) begin
            s_tdata = 32'(b); s_tlast = (b == 5);
            #1;
            chk($sformatf("t2_busy_b%0d", b), 64'(busy), 64'd1);
            chk($sformatf("t2_m_tvalid_b%0d", b), 64'(m_tvalid), 64'd1);
            chk($sformatf("t2_m_tdata_b%0d", b), 64'(m_tdata), 64'(b));
            chk($sformatf("t2_s_tready_b%0d", b), 64'(s_tready), 64'd1);
            nxt();
        end
        s_tdata = 32'h77; s_tlast = 1'b1;
        for (int c = 0; c < 7; c++) begin
            #1;
            chk($sformatf("t2_held_m_tvalid_%0d", c), 64'(m_tvalid), 64'd0);
            chk($sformatf("t2_held_s_tready_%0d", c), 64'(s_tready), 64'd0);
            chk($sformatf("t2_held_sel_%0d", c), 64'(sel), 64'd2);
            nxt();
        end
        #1;
        chk("t2_sel_new", 64'(sel), 64'd1);
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_rel_m_tvalid", 64'(m_tvalid), 64'd1);
        chk("t2_rel_s_tready", 64'(s_tready), 64'd1);
        chk("t2_rel_m_tdata", 64'(m_tdata), 64'h77);
        nxt();
        s_tvalid = 1'b0; s_tlast = 1'b0;

        // 3: egress packet during DRAIN; switch lands 4 idle cycles after egress tlast
        req_valid = 1'b1; req_sel = 3'd3;
        nxt();
        req_valid = 1'b0;
        nxt(); // cycle 2: DRAIN begins
        for (int c = 2; c <= 12; c++) begin
            e_tvalid = (c == 2) || (c == 4) || (c == 6);
            e_tlast  = (c == 6);
            #1;
            chk($sformatf("t3_busy_c%0d", c), 64'(busy), 64'd1);
            chk($sformatf("t3_sel_c%0d", c), 64'(sel), 64'd1);
            nxt();
        end
        e_tvalid = 1'b0; e_tlast = 1'b0;
        #1;
        chk("t3_sel_c13", 64'(sel), 64'd3);
        chk("t3_done_c13", 64'(done), 64'd1);
        chk("t3_busy_c13", 64'(busy), 64'd0);
        nxt();

        // 5: reset while mid-packet with a request pending
        s_tvalid = 1'b1; s_tdata = 32'hBEEF; s_tlast = 1'b0;
        req_valid = 1'b1; req_sel = 3'd2;
        nxt();
        req_valid = 1'b0; s_tvalid = 1'b0;
        #1 chk("t5_busy_pre", 64'(busy), 64'd1);
        resetn = 1'b0;
        nxt();
        resetn = 1'b1;
        #1;
        chk("t5_sel", 64'(sel), 64'd0);
        chk("t5_done", 64'(done), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        s_tvalid = 1'b1; s_tdata = 32'hCAFE; s_tlast = 1'b1;
        #1;
        chk("t5_m_tvalid", 64'(m_tvalid), 64'd1);
        chk("t5_s_tready", 64'(s_tready), 64'd1);
        chk("t5_m_tdata", 64'(m_tdata), 64'hCAFE);
        nxt();
        s_tvalid = 1'b0;
        #1 chk("t5_sel_stable", 64'(sel), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
